// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Round-robin arbitration is selected at build time with ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int MEM_DEPTH = 64;
    localparam int ADR_W     = 8;
    localparam int WD_W      = 8;
    localparam int RD_W      = 14;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACC_CPU  = 2'd1,
        ACC_HOST = 2'd2,
        RSP      = 2'd3
    } arb_state_t;

    typedef enum logic {
        CPU  = 1'b0,
        HOST = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between CPU (bit 0) and host (bit 1).
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise host has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_m,
    input  arb_owner_t last_grant,
    input  logic       host_lock,
    input  logic       locked,
    output logic [1:0] gnt,
    output logic       gnt_valid
);

    logic hold_s;

    assign hold_s = host_lock & locked;

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = (last_grant == HOST);
`endif

    // Winner decode; a held lock blocks the CPU even while the host is idle.
    always_comb begin
        gnt = 2'b00;
        if (hold_s) begin
            gnt = {req_m[1], 1'b0};
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            if (req_m == 2'b11) begin
                gnt = (last_grant == HOST) ? 2'b01 : 2'b10;
            end else begin
                gnt = req_m;
            end
`else
            if (req_m[1]) begin
                gnt = 2'b10;
            end else begin
                gnt = req_m;
            end
`endif
        end
        gnt_valid = |gnt;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port 64x14 unified memory between the CPU control unit and the host port.
// Build option: ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = ADR_W,
    parameter int DW    = WD_W,
    parameter int RW    = RD_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_ack,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_adr,
    input  logic [DW-1:0] host_wd,
    output logic          host_ack,
    input  logic          host_lock,
    output logic [RW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [RW-1:0] mem_rd
);

    arb_state_t    state_r, state_n_s;
    arb_owner_t    owner_r, last_grant_r, winner_s;
    logic          lat_we_r;
    logic [AW-1:0] lat_adr_r;
    logic [DW-1:0] lat_wd_r;
    logic          cpu_ack_r, host_ack_r, err_r;
    logic [RW-1:0] rdata_r;
    logic [1:0]    req_m_s, gnt_s;
    logic          gnt_valid_s, locked_s, acc_s, in_range_s;

    assign acc_s      = (state_r == ACC_CPU) || (state_r == ACC_HOST);
    assign in_range_s = ({{(32-AW){1'b0}}, lat_adr_r} < DEPTH);
    assign locked_s   = (last_grant_r == HOST);
    assign winner_s   = gnt_s[1] ? HOST : CPU;

    // Memory side is driven only from latched fields and the state register.
    assign mem_adr  = lat_adr_r;
    assign mem_wd   = lat_wd_r;
    assign mem_we   = acc_s & lat_we_r & in_range_s;
    assign cpu_ack  = cpu_ack_r;
    assign host_ack = host_ack_r;
    assign err      = err_r;
    assign rdata    = rdata_r;

    // Requests eligible for the pick; the finishing owner is still releasing its req in RSP.
    always_comb begin
        req_m_s = 2'b00;
        case (state_r)
            IDLE: req_m_s = {host_req, cpu_req};
            RSP: begin
                if (owner_r == HOST) begin
                    req_m_s = {1'b0, cpu_req};
                end else begin
                    req_m_s = {host_req, 1'b0};
                end
            end
            default: req_m_s = 2'b00;
        endcase
    end

    arb_pick u_pick (
        .req_m      (req_m_s),
        .last_grant (last_grant_r),
        .host_lock  (host_lock),
        .locked     (locked_s),
        .gnt        (gnt_s),
        .gnt_valid  (gnt_valid_s)
    );

    // Next-state decode.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE, RSP: begin
                if (gnt_valid_s) begin
                    state_n_s = gnt_s[1] ? ACC_HOST : ACC_CPU;
                end else begin
                    state_n_s = IDLE;
                end
            end
            ACC_CPU, ACC_HOST: state_n_s = RSP;
            default: state_n_s = IDLE;
        endcase
    end

    // State, request latch, read word and completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= CPU;
            last_grant_r <= HOST;
            lat_we_r     <= 1'b0;
            lat_adr_r    <= {AW{1'b0}};
            lat_wd_r     <= {DW{1'b0}};
            cpu_ack_r    <= 1'b0;
            host_ack_r   <= 1'b0;
            err_r        <= 1'b0;
            rdata_r      <= {RW{1'b0}};
        end else begin
            state_r <= state_n_s;
            if (gnt_valid_s) begin
                owner_r      <= winner_s;
                last_grant_r <= winner_s;
                lat_we_r     <= gnt_s[1] ? host_we  : cpu_we;
                lat_adr_r    <= gnt_s[1] ? host_adr : cpu_adr;
                lat_wd_r     <= gnt_s[1] ? host_wd  : cpu_wd;
            end
            cpu_ack_r  <= (state_r == ACC_CPU);
            host_ack_r <= (state_r == ACC_HOST);
            err_r      <= acc_s & ~in_range_s;
            if (acc_s) begin
                rdata_r <= in_range_s ? mem_rd : {RW{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 64x14 memory.
// Expected order for simultaneous requests follows ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset, preload;
    logic        cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [7:0]  cpu_adr, cpu_wd, host_adr, host_wd;
    logic        cpu_ack, host_ack, err, mem_we;
    logic [13:0] rdata, mem_rd;
    logic [7:0]  mem_adr, mem_wd;
    logic [13:0] mem [64];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd), .cpu_ack(cpu_ack),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wd(host_wd),
        .host_ack(host_ack), .host_lock(host_lock),
        .rdata(rdata), .err(err),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    function automatic logic [13:0] init_word(input int i);
        case (i)
            6:       return 14'h0ABC;
            18:      return 14'h3657;
            32:      return 14'h3C00;
            40:      return 14'h1234;
            default: return 14'(i);
        endcase
    endfunction

    // Memory ignores the upper address bits, like the real 64-word array.
    assign mem_rd = mem[mem_adr[5:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_adr[5:0]][7:0] <= mem_wd;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_cpu_ack got=%b exp=0", cpu_ack); end
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL reset_host_ack got=%b exp=0", host_ack); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (rdata !== 14'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        checks++; if (mem_adr !== 8'h00) begin failures++; $display("FAIL reset_mem_adr got=%h exp=00", mem_adr); end
    endtask

    task automatic test_cpu_read();
        int we_cnt = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'd18; cpu_wd = 8'h00;
        @(negedge clk);
        we_cnt += int'(mem_we);
        checks++; if (mem_adr !== 8'd18) begin failures++; $display("FAIL cpu_read_acc_adr got=%0d exp=18", mem_adr); end
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL cpu_read_early_ack got=%b exp=0", cpu_ack); end
        @(negedge clk);
        we_cnt += int'(mem_we);
        checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL cpu_read_ack got=%b exp=1", cpu_ack); end
        checks++; if (rdata !== 14'h3657) begin failures++; $display("FAIL cpu_read_rdata got=%h exp=3657", rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL cpu_read_err got=%b exp=0", err); end
        cpu_req = 1'b0;
        @(negedge clk);
        we_cnt += int'(mem_we);
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL cpu_read_ack_pulse got=%b exp=0", cpu_ack); end
        checks++; if (we_cnt != 0) begin failures++; $display("FAIL cpu_read_mem_we got=%0d exp=0", we_cnt); end
    endtask

    task automatic test_host_write();
        int we_cnt = 0;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_adr = 8'd32; host_wd = 8'hA5;
        @(negedge clk);
        we_cnt += int'(mem_we);
        checks++; if (mem_wd !== 8'hA5) begin failures++; $display("FAIL host_write_wd got=%h exp=a5", mem_wd); end
        checks++; if (mem_adr !== 8'd32) begin failures++; $display("FAIL host_write_adr got=%0d exp=32", mem_adr); end
        @(negedge clk);
        we_cnt += int'(mem_we);
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL host_write_ack got=%b exp=1", host_ack); end
        host_req = 1'b0;
        @(negedge clk);
        we_cnt += int'(mem_we);
        checks++; if (we_cnt != 1) begin failures++; $display("FAIL host_write_we_cycles got=%0d exp=1", we_cnt); end
        checks++; if (mem[32] !== 14'h3CA5) begin failures++; $display("FAIL host_write_mem got=%h exp=3ca5", mem[32]); end
        host_req = 1'b1; host_we = 1'b0; host_wd = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL host_read_ack got=%b exp=1", host_ack); end
        checks++; if (rdata[7:0] !== 8'hA5) begin failures++; $display("FAIL host_read_rdata got=%h exp=a5", rdata[7:0]); end
        host_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int cpu_at = 0;
        int host_at = 0;
        int exp_cpu, exp_host;
`ifdef ARB_ROUND_ROBIN_EN
        exp_cpu = 2; exp_host = 4;
`else
        exp_cpu = 4; exp_host = 2;
`endif
        do_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'd18;
        host_req = 1'b1; host_we = 1'b0; host_adr = 8'd32;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (cpu_ack && host_ack) begin failures++; $display("FAIL sim_double_ack cycle=%0d got=11 exp=not both", c); end
            if (cpu_ack && cpu_at == 0) begin
                cpu_at = c; cpu_req = 1'b0;
                checks++; if (rdata !== 14'h3657) begin failures++; $display("FAIL sim_cpu_rdata got=%h exp=3657", rdata); end
            end
            if (host_ack && host_at == 0) begin
                host_at = c; host_req = 1'b0;
                checks++; if (rdata !== 14'h3CA5) begin failures++; $display("FAIL sim_host_rdata got=%h exp=3ca5", rdata); end
            end
        end
        checks++; if (cpu_at != exp_cpu) begin failures++; $display("FAIL sim_cpu_ack_cycle got=%0d exp=%0d", cpu_at, exp_cpu); end
        checks++; if (host_at != exp_host) begin failures++; $display("FAIL sim_host_ack_cycle got=%0d exp=%0d", host_at, exp_host); end
    endtask

    task automatic test_lock();
        int  host_acks = 0;
        int  cpu_wait = 0;
        logic cpu_early = 1'b0;
        do_reset();
        @(negedge clk);
        host_lock = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_adr = 8'd18;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'd32;
        for (int c = 1; c <= 20 && host_acks < 3; c++) begin
            @(negedge clk);
            if (cpu_ack) cpu_early = 1'b1;
            if (host_ack) begin
                host_acks++;
                checks++; if (rdata !== 14'h3657) begin failures++; $display("FAIL lock_host_rdata got=%h exp=3657", rdata); end
            end
        end
        host_req = 1'b0; host_lock = 1'b0;
        checks++; if (host_acks != 3) begin failures++; $display("FAIL lock_host_acks got=%0d exp=3", host_acks); end
        checks++; if (cpu_early !== 1'b0) begin failures++; $display("FAIL lock_cpu_early got=%b exp=0", cpu_early); end
        for (int c = 1; c <= 4 && cpu_wait == 0; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cpu_wait = c;
                checks++; if (rdata !== 14'h3CA5) begin failures++; $display("FAIL lock_cpu_rdata got=%h exp=3ca5", rdata); end
            end
        end
        checks++; if (cpu_wait < 1 || cpu_wait > 2) begin failures++; $display("FAIL lock_cpu_latency got=%0d exp=1..2", cpu_wait); end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int ack_cnt = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 8'd40; cpu_wd = 8'h5A;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL midrst_acc_we got=%b exp=1", mem_we); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL midrst_we_drop got=%b exp=0", mem_we); end
        checks++; if (mem_adr !== 8'h00) begin failures++; $display("FAIL midrst_mem_adr got=%h exp=00", mem_adr); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (rdata !== 14'h0000) begin failures++; $display("FAIL midrst_rdata got=%h exp=0000", rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", err); end
        checks++; if (mem[40] !== 14'h1234) begin failures++; $display("FAIL midrst_mem40 got=%h exp=1234", mem[40]); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ack_cnt += int'(cpu_ack) + int'(host_ack);
        end
        checks++; if (ack_cnt != 0) begin failures++; $display("FAIL midrst_no_ack got=%0d exp=0", ack_cnt); end
    endtask

    task automatic test_out_of_range();
        int we_cnt = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 8'd70; cpu_wd = 8'hFF;
        @(negedge clk);
        we_cnt += int'(mem_we);
        @(negedge clk);
        we_cnt += int'(mem_we);
        checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL oor_ack got=%b exp=1", cpu_ack); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", err); end
        checks++; if (rdata !== 14'h0000) begin failures++; $display("FAIL oor_rdata got=%h exp=0000", rdata); end
        cpu_req = 1'b0;
        @(negedge clk);
        we_cnt += int'(mem_we);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_err_pulse got=%b exp=0", err); end
        checks++; if (we_cnt != 0) begin failures++; $display("FAIL oor_mem_we got=%0d exp=0", we_cnt); end
        checks++; if (mem[6] !== 14'h0ABC) begin failures++; $display("FAIL oor_mem_alias got=%h exp=0abc", mem[6]); end
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 8'h00; cpu_wd = 8'h00;
        host_req = 1'b0; host_we = 1'b0; host_adr = 8'h00; host_wd = 8'h00; host_lock = 1'b0;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        test_reset();
        reset = 1'b0;
        test_cpu_read();
        test_host_write();
        test_simultaneous();
        test_lock();
        test_reset_mid_access();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
